// File: rtl/shift_add_mult4.sv
// shift_add_mult4: sequential shift-add unsigned multiplier.
// Drives the select of the upstream 2:1 operand mux: it captures the
// multiplicand (operand_sel=0) and then the multiplier (operand_sel=1) from
// din on two consecutive edges. It then runs WIDTH shift-add iterations and
// pulses done for one cycle with the 2*WIDTH-bit product.
//
// Handshake: start is a request level sampled only in IDLE. busy is high in
// every other state. done is a single-cycle pulse. product is valid from the
// done cycle on and holds until the next result or reset.
//
// Optional build macro ZERO_SKIP_EN: a zero operand seen in LOAD_B writes
// product=0 and jumps straight to DONE, skipping the CALC iterations.
module shift_add_mult4 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   din,
    output logic               operand_sel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        CALC   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The state register is the observation point for checkers; every
    // output below is decoded from it.
    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;

    // One iteration: conditional add with the carry kept in the top bit.
    logic [WIDTH:0] sum;
    logic           last_iter;
    logic           zero_operand;

    assign sum       = {1'b0, acc} + ({1'b0, mcand} & {(WIDTH+1){mplier[0]}});
    assign last_iter = (count == CNT_W'(WIDTH - 1));

`ifdef ZERO_SKIP_EN
    assign zero_operand = (mcand == '0) || (din == '0);
`else
    assign zero_operand = 1'b0;
`endif

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD_B;
            LOAD_B:  state_next = zero_operand ? DONE : CALC;
            CALC:    if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the state register only.
    always_comb begin
        operand_sel = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE:    ;
            LOAD_B:  begin operand_sel = 1'b1; busy = 1'b1; end
            CALC:    busy = 1'b1;
            DONE:    begin busy = 1'b1; done = 1'b1; end
            default: ;
        endcase
    end

    // Datapath: operand capture, shift-add iterations and the product write.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) mcand <= din;
                end
                LOAD_B: begin
                    mplier <= din;
                    acc    <= '0;
                    count  <= '0;
                    if (zero_operand) product <= '0;
                end
                CALC: begin
                    // {acc,mplier} <= {sum,mplier} >> 1
                    acc    <= sum[WIDTH:1];
                    mplier <= {sum[0], mplier[WIDTH-1:1]};
                    count  <= count + CNT_W'(1);
                    if (last_iter) product <= {sum, mplier[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult4.sv
// Directed testbench for shift_add_mult4. The upstream operand mux is
// modelled here: din = operand_sel ? mux_b : mux_a.
module tb_shift_add_mult4;

    localparam int W = 4;
`ifdef ZERO_SKIP_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 6;
`endif
    localparam int STD_LAT = 6;
    localparam int MAX_WAIT = 30;

    logic           clk;
    logic           reset;
    logic           start;
    logic [W-1:0]   din;
    logic           operand_sel;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    logic [W-1:0]   mux_a;
    logic [W-1:0]   mux_b;

    int total;
    int bad;

    logic [2*W-1:0] exp_q[$];

    // Clock and mux model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign din = operand_sel ? mux_b : mux_a;

    shift_add_mult4 #(.WIDTH(W), .CNT_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .din         (din),
        .operand_sel (operand_sel),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        mux_a = 4'd0;
        mux_b = 4'd0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({operand_sel, busy, done, product} !== 11'd0) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: sel=%b busy=%b done=%b product=%h, want all 0",
                         i, operand_sel, busy, done, product);
            end
        end
    endtask

    // Pulse start for one cycle and follow the operation to its done pulse.
    task automatic run_op(input string name, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp_p,
                          input int exp_lat);
        int n;
        logic [2*W-1:0] e;
        mux_a = a;
        mux_b = b;
        start = 1'b1;
        exp_q.push_back(exp_p);
        tick();
        start = 1'b0;
        n = 1;
        total++;
        if (operand_sel !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s load_b: sel=%b busy=%b, want 1 1", name, operand_sel, busy);
        end
        while (done !== 1'b1 && n < MAX_WAIT) begin
            tick();
            n++;
            total++;
            if (operand_sel !== 1'b0) begin
                bad++;
                $display("FAIL %s sel_after_load: sel=%b at cycle %0d, want 0", name, operand_sel, n);
            end
        end
        total++;
        if (n != exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d, want %0d", name, n, exp_lat);
        end
        e = exp_q.pop_front();
        total++;
        if (product !== e || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s product: got %h busy=%b, want %h busy=1", name, product, busy, e);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== e) begin
            bad++;
            $display("FAIL %s after_done: done=%b busy=%b product=%h, want 0 0 %h",
                     name, done, busy, product, e);
        end
    endtask

    task automatic test_basic();
        run_op("mul_3x5", 4'd3, 4'd5, 8'h0F, STD_LAT);
    endtask

    task automatic test_boundary();
        run_op("mul_15x15", 4'd15, 4'd15, 8'hE1, STD_LAT);
        run_op("mul_0x9", 4'd0, 4'd9, 8'h00, ZERO_LAT);
        run_op("mul_9x0", 4'd9, 4'd0, 8'h00, ZERO_LAT);
        run_op("mul_1x15", 4'd1, 4'd15, 8'h0F, STD_LAT);
    endtask

    // start held high: results every WIDTH+3 cycles.
    task automatic test_back_to_back();
        int n;
        mux_a = 4'd7;
        mux_b = 4'd9;
        start = 1'b1;
        exp_q.push_back(8'h3F);
        exp_q.push_back(8'h10);
        n = 0;
        while (done !== 1'b1 && n < MAX_WAIT) begin
            tick();
            n++;
        end
        total++;
        if (n != STD_LAT || product !== exp_q[0]) begin
            bad++;
            $display("FAIL b2b_first: latency=%0d product=%h, want %0d %h", n, product, STD_LAT, exp_q[0]);
        end
        void'(exp_q.pop_front());
        mux_a = 4'd2;
        mux_b = 4'd8;
        n = 0;
        tick();
        n++;
        while (done !== 1'b1 && n < MAX_WAIT) begin
            tick();
            n++;
        end
        start = 1'b0;
        total++;
        if (n != W + 3 || product !== exp_q[0]) begin
            bad++;
            $display("FAIL b2b_second: spacing=%0d product=%h, want %0d %h", n, product, W + 3, exp_q[0]);
        end
        void'(exp_q.pop_front());
        tick();
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: busy=%b, want 0", busy);
        end
    endtask

    // Reset in the third CALC cycle aborts without a done pulse.
    task automatic test_reset_abort();
        int seen;
        mux_a = 4'd12;
        mux_b = 4'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({operand_sel, busy, done, product} !== 11'd0) begin
            bad++;
            $display("FAIL abort_outputs: sel=%b busy=%b done=%b product=%h, want all 0",
                     operand_sel, busy, done, product);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL abort_quiet: %0d active cycles, want 0", seen);
        end
        run_op("mul_12x11", 4'd12, 4'd11, 8'h84, STD_LAT);
    endtask

    // start toggled and din changed during CALC must not disturb the result.
    task automatic test_busy_toggle();
        int n;
        int dones;
        mux_a = 4'd6;
        mux_b = 4'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n = 2;
        while (done !== 1'b1 && n < MAX_WAIT) begin
            if (n < 5) begin
                start = ~start;
                mux_a = 4'(n * 3 + 1);
                mux_b = 4'(n * 5 + 2);
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        total++;
        if (n != STD_LAT || product !== 8'h24) begin
            bad++;
            $display("FAIL toggle_6x6: latency=%0d product=%h, want %0d 24", n, product, STD_LAT);
        end
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 0 || product !== 8'h24) begin
            bad++;
            $display("FAIL toggle_extra_done: dones=%0d product=%h, want 0 24", dones, product);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_reset_abort();
        test_busy_toggle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
